// File: rtl/psum_quant_packer.sv
// +----------------------------------------------------------------------------+
// | psum_quant_packer: requantizes MAC sums, packs lanes, buffers packed words. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module psum_quant_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = DATA_WIDTH * 2 + 6,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_clear,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic [4:0]                 in_shift,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [PACK-1:0]            out_mask,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [15:0]                out_sat_count
);

  localparam int c_EXT_W  = IN_WIDTH + 1;
  localparam int c_WORD_W = PACK * DATA_WIDTH;
  localparam int c_LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_LANE_W-1:0] c_LANE_LAST     = c_LANE_W'(PACK - 1);
  localparam logic [c_PTR_W-1:0]  c_PTR_LAST      = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_READY_MAX = c_CNT_W'(FIFO_DEPTH - 2);
  localparam logic [c_CNT_W-1:0]  c_CNT_FULL      = c_CNT_W'(FIFO_DEPTH);
  localparam logic signed [c_EXT_W-1:0] c_QMAX = c_EXT_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [c_EXT_W-1:0] c_QMIN = ~c_QMAX;

  // ---------------------------------------------------------------------------
  // Quantizer: round-half-up arithmetic shift, then saturate
  // ---------------------------------------------------------------------------
  logic signed [c_EXT_W-1:0] w_ext;
  logic signed [c_EXT_W-1:0] w_rnd;
  logic signed [c_EXT_W-1:0] w_sum;
  logic signed [c_EXT_W-1:0] w_shr;
  logic                      w_sat_hi;
  logic                      w_sat_lo;
  logic                      w_sat;
  logic [DATA_WIDTH-1:0]     w_q;
  logic                      w_accept;

  // One extra bit of headroom keeps the rounding add from overflowing.
  assign w_ext    = {in_data[IN_WIDTH-1], in_data};
  assign w_rnd    = (in_shift != 5'd0) ? (c_EXT_W'(1) << (in_shift - 5'd1)) : '0;
  assign w_sum    = w_ext + w_rnd;
  assign w_shr    = w_sum >>> in_shift;
  assign w_sat_hi = (w_shr > c_QMAX);
  assign w_sat_lo = (w_shr < c_QMIN);
  assign w_sat    = w_sat_hi | w_sat_lo;
  assign w_q      = w_sat_hi ? c_QMAX[DATA_WIDTH-1:0] :
                    w_sat_lo ? c_QMIN[DATA_WIDTH-1:0] :
                               w_shr[DATA_WIDTH-1:0];

  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage S1
  // ---------------------------------------------------------------------------
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_byte;
  logic                  r_s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_byte  <= '0;
      r_s1_last  <= 1'b0;
    end else if (in_clear) begin
      r_s1_valid <= 1'b0;
      r_s1_byte  <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_byte <= w_q;
        r_s1_last <= in_last;
      end
    end
  end

  logic [15:0] r_sat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (in_clear) begin
      r_sat_count <= '0;
    end else if (w_accept && w_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  logic [c_LANE_W-1:0] r_lane;
  logic [c_WORD_W-1:0] r_word;
  logic [PACK-1:0]     r_mask;
  logic [c_WORD_W-1:0] w_word_next;
  logic [PACK-1:0]     w_lane_hit;
  logic [PACK-1:0]     w_mask_next;
  logic                w_push;

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    assign w_lane_hit[i] = r_s1_valid & (r_lane == c_LANE_W'(i));
    assign w_word_next[DATA_WIDTH*i +: DATA_WIDTH] =
        w_lane_hit[i] ? r_s1_byte : r_word[DATA_WIDTH*i +: DATA_WIDTH];
  end

  assign w_mask_next = r_mask | w_lane_hit;
  assign w_push      = r_s1_valid & ((r_lane == c_LANE_LAST) | r_s1_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_word <= '0;
      r_mask <= '0;
    end else if (in_clear || w_push) begin
      r_lane <= '0;
      r_word <= '0;
      r_mask <= '0;
    end else if (r_s1_valid) begin
      r_lane <= r_lane + 1'b1;
      r_word <= w_word_next;
      r_mask <= w_mask_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO
  // ---------------------------------------------------------------------------
  logic [c_WORD_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [PACK-1:0]     r_mem_mask [FIFO_DEPTH];
  logic                r_mem_last [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_do_pop;
  logic                w_do_push;
  logic [c_PTR_W-1:0]  w_wr_ptr_inc;
  logic [c_PTR_W-1:0]  w_rd_ptr_inc;

  assign w_do_pop     = (r_count != '0) & out_ready;
  assign w_do_push    = w_push & ((r_count != c_CNT_FULL) | w_do_pop);
  assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  // Storage carries no reset; every output is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_do_push && !in_clear) begin
      r_mem_data[r_wr_ptr] <= w_word_next;
      r_mem_mask[r_wr_ptr] <= w_mask_next;
      r_mem_last[r_wr_ptr] <= r_s1_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (in_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready      = ~in_clear & (r_count <= c_CNT_READY_MAX);
  assign out_valid     = (r_count != '0);
  assign out_data      = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_mask      = out_valid ? r_mem_mask[r_rd_ptr] : '0;
  assign out_last      = out_valid ? r_mem_last[r_rd_ptr] : 1'b0;
  assign out_sat_count = r_sat_count;

endmodule

`default_nettype wire

// File: tb/tb_psum_quant_packer.sv
// +----------------------------------------------------------------------------+
// | tb_psum_quant_packer: scoreboard bench for the quantize/pack/FIFO stage.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_psum_quant_packer;

  localparam int DW = 8;
  localparam int IW = DW * 2 + 6;
  localparam int PK = 4;
  localparam int FD = 4;

  logic          clk;
  logic          rst_n;
  logic          in_clear;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic [4:0]    in_shift;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [PK-1:0] out_mask;
  logic          out_last;
  logic          out_ready;
  logic [15:0]   out_sat_count;

  psum_quant_packer #(
    .DATA_WIDTH (DW),
    .IN_WIDTH   (IW),
    .PACK       (PK),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_clear      (in_clear),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_shift      (in_shift),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_mask      (out_mask),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .out_sat_count (out_sat_count)
  );

  typedef struct packed {
    logic [31:0]   data;
    logic [PK-1:0] mask;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a word leaves the DUT on every edge where head is valid and ready is high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("word_data", out_data, mon_e.data);
        check("word_mask", 32'(out_mask), 32'(mon_e.mask));
        check("word_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  task automatic send(input int v, input logic [4:0] sh, input logic last);
    int k = 0;
    in_valid = 1'b1;
    in_data  = IW'(v);
    in_shift = sh;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_tests++;
    if (sb.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL %s: pending words got %0d, expected 0", name, sb.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_clear  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_sat_count", 32'(out_sat_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Rounding with shift 4 and latency of the first word
    sb.push_back('{32'h00FEFF12, 4'hF, 1'b0});
    send(291, 5'd4, 1'b0);
    send(-24, 5'd4, 1'b0);
    send(-25, 5'd4, 1'b0);
    send(7,   5'd4, 1'b0);
    check("latency_t1_low", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_t2_high", 32'(out_valid), 32'd1);
    wait_drain("drain_round");
    check("sat_after_round", 32'(out_sat_count), 32'd0);

    // Saturation in both directions
    sb.push_back('{32'h7F057F80, 4'hF, 1'b0});
    send(-300, 5'd0, 1'b0);
    send(200,  5'd0, 1'b0);
    send(5,    5'd0, 1'b0);
    send(127,  5'd0, 1'b0);
    wait_drain("drain_sat");
    check("sat_count_2", 32'(out_sat_count), 32'd2);

    // Early emission on last, then lane-0 restart
    sb.push_back('{32'h00000201, 4'h3, 1'b1});
    sb.push_back('{32'h06050403, 4'hF, 1'b0});
    send(1, 5'd0, 1'b0);
    send(2, 5'd0, 1'b1);
    for (int i = 3; i <= 6; i++) send(i, 5'd0, 1'b0);
    wait_drain("drain_last");

    // Backpressure: three words fill the FIFO to the ready threshold
    out_ready = 1'b0;
    sb.push_back('{32'h13121110, 4'hF, 1'b0});
    sb.push_back('{32'h17161514, 4'hF, 1'b0});
    sb.push_back('{32'h1B1A1918, 4'hF, 1'b0});
    for (int i = 0; i < 12; i++) send(16 + i, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_head_data", out_data, 32'h13121110);
    out_ready = 1'b1;
    wait_drain("drain_bp");
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Synchronous clear with two words queued and a partial word in flight
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h31 + i, 5'd0, 1'b0);
    send(1000, 5'd0, 1'b0);
    send(8'h41, 5'd0, 1'b0);
    check("pre_clear_sat", 32'(out_sat_count), 32'd3);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_data  = IW'(5);
    @(posedge clk);
    #1;
    in_clear = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_sat_count", 32'(out_sat_count), 32'd0);
    out_ready = 1'b1;
    sb.push_back('{32'h24232221, 4'hF, 1'b0});
    for (int i = 0; i < 4; i++) send(8'h21 + i, 5'd0, 1'b0);
    wait_drain("drain_clear");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h51 + i, 5'd0, 1'b0);
    send(-2000, 5'd0, 1'b0);
    send(8'h55, 5'd0, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_mask", 32'(out_mask), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_sat_count", 32'(out_sat_count), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    sb.push_back('{32'h64636261, 4'hF, 1'b0});
    for (int i = 0; i < 4; i++) send(8'h61 + i, 5'd0, 1'b0);
    wait_drain("drain_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/psum_quant_packer.md
# psum_quant_packer

Downstream stage of the MAC cluster: consumes each finished signed total sum (`DATA_WIDTH*2+6` bits, post bias/ReLU) and requantizes it to a signed `DATA_WIDTH` activation using a round-half-up arithmetic right shift with saturation. It packs `PACK` activations per output word and buffers words in a small show-ahead FIFO with valid/ready handshake toward the activation buffer write port. It also keeps a saturation counter for quantization debug.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: output activation width.
- `IN_WIDTH`, default `DATA_WIDTH*2+6` (22): input sum width; matches the MAC cluster output.
- `PACK`, default 4: activations per output word.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be ≥2.

Ports:
- `clk`, in, 1: clock. Rising edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `in_clear`, in, 1: synchronous flush. Drops the partial word, empties the FIFO, zeroes `out_sat_count`.
- `in_valid`, in, 1: `in_data` valid.
- `in_data`, in, `IN_WIDTH`: signed sum.
- `in_shift`, in, 5: right-shift amount 0..`IN_WIDTH-1`. Sampled with `in_valid`.
- `in_last`, in, 1: last sum of the tile. Forces emission of the current word.
- `in_ready`, out, 1: input accepted when `in_valid & in_ready`.
- `out_valid`, out, 1: FIFO head valid.
- `out_data`, out, `PACK*DATA_WIDTH`: packed word. Lane i occupies bits `[DATA_WIDTH*i +: DATA_WIDTH]`.
- `out_mask`, out, `PACK`: lane-valid bits.
- `out_last`, out, 1: word ends a tile.
- `out_ready`, in, 1: pop when `out_valid & out_ready`.
- `out_sat_count`, out, 16: count of saturated results, sticky at 0xFFFF.

## Operation
- Quantize, on the signed value extended to `IN_WIDTH+1` bits: `r = (x + (s>0 ? 1<<(s-1) : 0)) >>> s`.
- Saturate `r` to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Stage S1 register holds: quantized byte, last flag, saturation flag, valid.
- Packer holds: lane counter 0..`PACK-1`, word register, mask register.
- When S1 is valid, its byte is written to the current lane and that lane's mask bit is set.
- The word is pushed when lane = `PACK-1` or the S1 last flag is set.
- The FIFO push value is formed combinationally, including the S1 byte.
- Unfilled lanes are 0.
- After a push, the lane counter, word and mask are cleared.
- `out_last` is the S1 last flag of the pushing element.
- `in_ready = ~in_clear & (fifo_count <= FIFO_DEPTH-2)`. This guarantees no overflow, because each accepted input pushes at most one word, exactly one cycle later.
- `out_sat_count` increments in the cycle S1 loads a saturated element, and holds at 0xFFFF.
- FIFO: pop and push in the same cycle are both performed; the count is unchanged. Pop of an empty FIFO is ignored.
- `in_clear` wins over all concurrent events:
  - the input that cycle is dropped;
  - S1 is invalidated;
  - the lane counter, word and mask are cleared;
  - the FIFO count and pointers are cleared;
  - `out_sat_count` is set to 0.
- Reset: all outputs 0 (`out_valid=0`, `out_data=0`, `out_mask=0`, `out_last=0`, `out_sat_count=0`). `in_ready=1` after reset deasserts. Reset mid-tile discards all state.

## Timing
- Input accepted in cycle t: S1 valid in t+1; FIFO push at the end of t+1.
- If the FIFO was empty, `out_valid` rises in t+2 with the word visible (show-ahead).
- Throughput: one input per cycle while `in_ready` is high, i.e. one word per `PACK` cycles.
- `in_ready` is a registered-count function; it drops the cycle after the count reaches `FIFO_DEPTH-1`.
- `out_*` change only on the clock after a pop or push.
- `in_shift` ≥ `IN_WIDTH` is illegal; the result is unspecified but must not hang.

## Test plan
- Shift 4, inputs 291, -24, -25, 7 (last=0) → `out_data` = 0x00FEFF12 (lanes 0x12, 0xFF, 0xFE, 0x00), mask 0xF, `out_valid` 2 cycles after the 4th accept.
- Shift 0, inputs -300, 200, 5, 127 → bytes 0x80, 0x7F, 0x05, 0x7F; `out_data` 0x7F057F80; `out_sat_count` = 2.
- Shift 0, inputs 1, 2 with `in_last` on the 2nd → `out_data` 0x00000201, mask 0x3, `out_last` 1. The next word restarts at lane 0.
- `out_ready=0`, 12 back-to-back inputs → 3 words queued and `in_ready` low. Raise `out_ready` → words are popped in order and `in_ready` reasserts. No word is lost or duplicated.
- `in_clear` asserted with `in_valid` mid-word and 2 words queued → next cycle: `out_valid=0`, `out_sat_count=0`; the following 4 inputs form a clean lane-0-aligned word.
- Assert `rst_n` low asynchronously mid-stream → all outputs 0 immediately. After release, `in_ready=1` and packing starts at lane 0.
